// File: rtl/rx_byte_port.sv
// -----------------------------------------------------------------------------
// rx_byte_port
//
// Polled receive port on the 8-bit I/O bus. An external producer hands bytes
// over with a dav_/rfd handshake; the bytes are queued in a small FIFO that
// the bus master drains by reading the receive buffer register.
//
//   BASE   : status register, reads {6'b0, FULL, FI}; a write with data[7]=1
//            flushes the FIFO, any other write is ignored.
//   BASE+1 : receive buffer, reads the FIFO head (8'h00 when empty); the byte
//            is popped on the clock after the read strobe is released.
//
// Ports
//   clock    in     1   system clock
//   reset_   in     1   asynchronous active-low reset
//   addr     in     16  bus address
//   data     inout  8   bus data, driven only during a matching read, else Z
//   ior_     in     1   read strobe, active low, one full clock
//   iow_     in     1   write strobe, active low, one full clock
//   byte_in  in     8   producer data, stable while dav_ is low
//   dav_     in     1   producer data-valid, active low, asynchronous
//   rfd      out    1   ready-for-data to the producer, active high
// -----------------------------------------------------------------------------
module rx_byte_port #(
  parameter logic [15:0] BASE  = 16'h0100,
  parameter int          DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_,
  input  logic [15:0] addr,
  inout  wire  [7:0]  data,
  input  logic        ior_,
  input  logic        iow_,
  input  logic [7:0]  byte_in,
  input  logic        dav_,
  output logic        rfd
);

  // Pointers and storage are sized for the largest legal depth (8) so the
  // same index width works for every DEPTH; unused entries are never written.
  localparam int PW = 3;
  localparam int CW = 4;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [15:0]   RBR_ADR  = BASE + 16'd1;

  typedef enum logic [0:0] {
    H_WAIT = 1'b0,
    H_ACK  = 1'b1
  } h_state_e;

  // Pointer increment with wrap at DEPTH (DEPTH need not be a power of two).
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == LAST_PTR) begin
      n = {PW{1'b0}};
    end else begin
      n = p + PW'(1);
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic          dav_meta_q, dav_meta_d;
  logic          dav_s_q, dav_s_d;
  h_state_e      state_q, state_d;
  logic          rfd_q, rfd_d;
  logic          r_pend_q, r_pend_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [0:7];
  logic [7:0]    mem_d [0:7];

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic       st_sel_s;
  logic       rd_sel_s;
  logic       fi_s;
  logic       full_s;
  logic       flush_s;
  logic       hs_push_s;
  logic       fifo_push_s;
  logic       pop_s;
  logic       drive_s;
  logic [7:0] rd_data_s;

  // Bus decode, status flags and the combinational read mux.
  always_comb begin
    st_sel_s  = (ior_ == 1'b0) && (addr == BASE);
    rd_sel_s  = (ior_ == 1'b0) && (addr == RBR_ADR);
    fi_s      = (count_q != {CW{1'b0}});
    full_s    = (count_q == FULL_CNT);
    flush_s   = (iow_ == 1'b0) && (addr == BASE) && (data[7] == 1'b1);
    // The bus is released while reset is held, even under an active strobe.
    drive_s   = reset_ && (st_sel_s || rd_sel_s);
    rd_data_s = 8'h00;
    if (st_sel_s) begin
      rd_data_s = {6'b000000, full_s, fi_s};
    end else if (rd_sel_s && fi_s) begin
      rd_data_s = mem_q[rd_ptr_q];
    end else begin
      rd_data_s = 8'h00;
    end
  end

  assign data = drive_s ? rd_data_s : 8'bzzzzzzzz;
  assign rfd  = rfd_q;

  // Synchroniser inputs and read-pending tracking.
  always_comb begin
    dav_meta_d = dav_;
    dav_s_d    = dav_meta_q;
    // Remember a non-empty RBR read so the pop lands after the strobe ends,
    // keeping the head stable for the whole strobe.
    r_pend_d   = rd_sel_s && fi_s;
    // The fi_s term guards against a flush that emptied the FIFO meanwhile.
    pop_s      = r_pend_q && (ior_ == 1'b1) && fi_s;
  end

  // Producer handshake FSM: next state, rfd and push request.
  always_comb begin
    state_d   = state_q;
    rfd_d     = rfd_q;
    hs_push_s = 1'b0;
    case (state_q)
      H_WAIT: begin
        if ((dav_s_q == 1'b0) && !full_s) begin
          hs_push_s = 1'b1;
          rfd_d     = 1'b0;
          state_d   = H_ACK;
        end else begin
          rfd_d     = !full_s;
          state_d   = H_WAIT;
        end
      end
      H_ACK: begin
        if (dav_s_q == 1'b1) begin
          // Use the post-update count so a pop this cycle is seen at once.
          rfd_d   = (count_d != FULL_CNT);
          state_d = H_WAIT;
        end else begin
          rfd_d   = 1'b0;
          state_d = H_ACK;
        end
      end
      default: begin
        rfd_d   = 1'b1;
        state_d = H_WAIT;
      end
    endcase
  end

  // FIFO update: flush beats push/pop; push and pop together keep the count.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    fifo_push_s = hs_push_s && !flush_s;
    if (flush_s) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (fifo_push_s) begin
        mem_d[wr_ptr_q] = byte_in;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({fifo_push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // dav_ synchroniser and handshake registers.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      dav_meta_q <= 1'b1;
      dav_s_q    <= 1'b1;
      state_q    <= H_WAIT;
      rfd_q      <= 1'b1;
      r_pend_q   <= 1'b0;
    end else begin
      dav_meta_q <= dav_meta_d;
      dav_s_q    <= dav_s_d;
      state_q    <= state_d;
      rfd_q      <= rfd_d;
      r_pend_q   <= r_pend_d;
    end
  end

  // FIFO pointers, occupancy and storage.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      count_q  <= {CW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < 8; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_rx_byte_port.sv
// Bench for rx_byte_port. Bytes handed to the producer side are queued as the
// expected receive stream and popped when the RBR is read. The data bus has a
// pull-up, so a released (Z) bus reads back as 8'hFF.
module tb_rx_byte_port;
  localparam logic [15:0] BASE = 16'h0100;
  localparam logic [15:0] RBR  = 16'h0101;

  logic        clock = 1'b0;
  logic        reset_;
  logic [15:0] addr;
  logic        ior_;
  logic        iow_;
  logic [7:0]  byte_in;
  logic        dav_;
  logic        rfd;
  logic [7:0]  tb_drv;
  logic        tb_drv_en;
  wire  [7:0]  data;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];

  assign data = tb_drv_en ? tb_drv : 8'bzzzzzzzz;
  pullup (data);

  rx_byte_port #(.BASE(16'h0100), .DEPTH(4)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .addr   (addr),
    .data   (data),
    .ior_   (ior_),
    .iow_   (iow_),
    .byte_in(byte_in),
    .dav_   (dav_),
    .rfd    (rfd)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic bus_read(input logic [15:0] a, output logic [7:0] v);
    @(negedge clock);
    addr = a;
    ior_ = 1'b0;
    #2;
    v = data;
    @(negedge clock);
    ior_ = 1'b1;
    addr = 16'h0000;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    addr      = a;
    tb_drv    = d;
    tb_drv_en = 1'b1;
    iow_      = 1'b0;
    @(negedge clock);
    iow_      = 1'b1;
    tb_drv_en = 1'b0;
    addr      = 16'h0000;
  endtask

  // Full producer handshake; expects rfd to fall within a bounded wait.
  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clock);
    byte_in = b;
    dav_    = 1'b0;
    exp_q.push_back(b);
    n = 0;
    while (rfd !== 1'b0 && n < 12) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (rfd !== 1'b0) begin
      bad++;
      $display("FAIL send_rfd_fall byte=%h: rfd=%b required 0", b, rfd);
    end
    dav_ = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    reset_ = 1'b0; addr = 16'h0000; ior_ = 1'b1; iow_ = 1'b1;
    byte_in = 8'h00; dav_ = 1'b1; tb_drv = 8'h00; tb_drv_en = 1'b0;
    repeat (3) @(negedge clock);
    reset_ = 1'b1;
    @(negedge clock);
    total++;
    if (rfd !== 1'b1) begin bad++; $display("FAIL reset_rfd: got %b want 1", rfd); end
    total++;
    if (data !== 8'hFF) begin bad++; $display("FAIL reset_bus_idle: got %h want ff", data); end
    bus_read(BASE, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL reset_status: got %h want 00", v); end
    bus_read(RBR, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL empty_rbr: got %h want 00", v); end
    bus_read(BASE, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL empty_rbr_status: got %h want 00", v); end
  endtask

  task automatic test_single();
    logic [7:0] v;
    logic [7:0] e;
    send_byte(8'hA5);
    bus_read(BASE, v);
    total++;
    if (v !== 8'h01) begin bad++; $display("FAIL single_status: got %h want 01", v); end
    bus_read(RBR, v);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    total++;
    if (v !== e) begin bad++; $display("FAIL single_rbr: got %h want %h", v, e); end
    bus_read(BASE, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL single_status_after: got %h want 00", v); end
  endtask

  task automatic test_fill();
    logic [7:0] v;
    logic [7:0] e;
    logic [7:0] pat [4];
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
    for (int i = 0; i < 4; i++) send_byte(pat[i]);
    bus_read(BASE, v);
    total++;
    if (v !== 8'h03) begin bad++; $display("FAIL fill_status: got %h want 03", v); end
    total++;
    if (rfd !== 1'b0) begin bad++; $display("FAIL fill_rfd: got %b want 0", rfd); end
    // Fifth byte offered while full: must be held off.
    @(negedge clock);
    byte_in = 8'h55;
    dav_    = 1'b0;
    exp_q.push_back(8'h55);
    repeat (6) @(negedge clock);
    total++;
    if (rfd !== 1'b0) begin bad++; $display("FAIL full_hold_rfd: got %b want 0", rfd); end
    bus_read(BASE, v);
    total++;
    if (v !== 8'h03) begin bad++; $display("FAIL full_hold_status: got %h want 03", v); end
    bus_read(RBR, v);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    total++;
    if (v !== e) begin bad++; $display("FAIL full_first_pop: got %h want %h", v, e); end
    repeat (3) @(negedge clock);
    bus_read(BASE, v);
    total++;
    if (v !== 8'h03) begin bad++; $display("FAIL held_byte_accepted: got %h want 03", v); end
    dav_ = 1'b1;
    repeat (4) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      bus_read(RBR, v);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      total++;
      if (v !== e) begin bad++; $display("FAIL fill_drain[%0d]: got %h want %h", i, v, e); end
    end
    bus_read(BASE, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL fill_empty_status: got %h want 00", v); end
    total++;
    if (rfd !== 1'b1) begin bad++; $display("FAIL fill_rfd_back: got %b want 1", rfd); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    logic [7:0] e;
    send_byte(8'h66);
    send_byte(8'h77);
    // dav_ falls here; the synchronised push lands on the third posedge,
    // which is the same edge as the pop following the RBR strobe below.
    @(negedge clock);
    byte_in = 8'h88;
    dav_    = 1'b0;
    exp_q.push_back(8'h88);
    bus_read(RBR, v);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    total++;
    if (v !== e) begin bad++; $display("FAIL b2b_pop: got %h want %h", v, e); end
    repeat (3) @(negedge clock);
    total++;
    if (rfd !== 1'b0) begin bad++; $display("FAIL b2b_rfd: got %b want 0", rfd); end
    dav_ = 1'b1;
    repeat (4) @(negedge clock);
    // Count should still be 2, so two more bytes make it exactly full.
    send_byte(8'h99);
    send_byte(8'hAA);
    bus_read(BASE, v);
    total++;
    if (v !== 8'h03) begin bad++; $display("FAIL b2b_count: got %h want 03", v); end
    for (int i = 0; i < 4; i++) begin
      bus_read(RBR, v);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      total++;
      if (v !== e) begin bad++; $display("FAIL b2b_drain[%0d]: got %h want %h", i, v, e); end
    end
    bus_read(BASE, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL b2b_empty: got %h want 00", v); end
  endtask

  task automatic test_flush();
    logic [7:0] v;
    logic [7:0] e;
    send_byte(8'hB1);
    send_byte(8'hB2);
    send_byte(8'hB3);
    bus_write(BASE, 8'h80);
    exp_q.delete();
    bus_read(BASE, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL flush_status: got %h want 00", v); end
    bus_read(RBR, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL flush_rbr: got %h want 00", v); end
    send_byte(8'hC1);
    bus_write(BASE, 8'h00);
    bus_read(BASE, v);
    total++;
    if (v !== 8'h01) begin bad++; $display("FAIL nonflush_status: got %h want 01", v); end
    bus_read(RBR, v);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    total++;
    if (v !== e) begin bad++; $display("FAIL nonflush_rbr: got %h want %h", v, e); end
    bus_read(BASE, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL nonflush_empty: got %h want 00", v); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    int n;
    @(negedge clock);
    byte_in = 8'hD1;
    dav_    = 1'b0;
    n = 0;
    while (rfd !== 1'b0 && n < 12) begin
      @(negedge clock);
      n++;
    end
    total++;
    if (rfd !== 1'b0) begin bad++; $display("FAIL mid_hs_rfd: got %b want 0", rfd); end
    // Still in H_ACK (dav_ low) with one byte queued; start an RBR strobe.
    @(negedge clock);
    addr = RBR;
    ior_ = 1'b0;
    #2;
    v = data;
    total++;
    if (v !== 8'hD1) begin bad++; $display("FAIL mid_rbr: got %h want d1", v); end
    #1;
    reset_ = 1'b0;
    #1;
    total++;
    if (rfd !== 1'b1) begin bad++; $display("FAIL async_reset_rfd: got %b want 1", rfd); end
    total++;
    if (data !== 8'hFF) begin bad++; $display("FAIL async_reset_bus: got %h want ff", data); end
    @(negedge clock);
    ior_   = 1'b1;
    addr   = 16'h0000;
    dav_   = 1'b1;
    reset_ = 1'b1;
    exp_q.delete();
    repeat (4) @(negedge clock);
    bus_read(BASE, v);
    total++;
    if (v !== 8'h00) begin bad++; $display("FAIL post_reset_status: got %h want 00", v); end
    total++;
    if (rfd !== 1'b1) begin bad++; $display("FAIL post_reset_rfd: got %b want 1", rfd); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
